// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: ID/EX/MEM/WB control pipeline with forwarding, load-use stall and flush.
// Optional saturating perf counters when CTRL_PIPE_PERF_EN is defined.
package ctrl_pipe_hazard_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_t;

  localparam logic [1:0] RES_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

module ctrl_pipe_hazard
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            ctrl_d,
  input  logic [REG_AW-1:0]     rs1_d,
  input  logic [REG_AW-1:0]     rs2_d,
  input  logic [REG_AW-1:0]     rd_d,
  input  logic                  zero_e,
  output logic [2:0]            alu_control_e,
  output logic                  alu_src_e,
  output logic                  mem_write_m,
  output logic [1:0]            result_src_w,
  output logic                  reg_write_w,
  output logic [REG_AW-1:0]     rd_w,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  pc_src_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic [REG_AW-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
  } mem_wb_t;

  id_ex_t  e_q, e_d;
  ex_mem_t m_q, m_d;
  mem_wb_t w_q, w_d;

  logic lw_stall;
  logic flush_e;
  logic hit_m_a, hit_w_a;
  logic hit_m_b, hit_w_b;

  assign lw_stall = (e_q.ctrl.result_src == RES_LOAD)
                  && (e_q.rd != '0)
                  && ((rs1_d == e_q.rd) || (rs2_d == e_q.rd));

  assign pc_src_e = (e_q.ctrl.branch & zero_e) | e_q.ctrl.jump;

  // A redirect and a load-use stall can coincide; both just bubble E.
  assign flush_e = lw_stall | pc_src_e;

  assign stall_f = lw_stall;
  assign stall_d = lw_stall;
  assign flush_d = pc_src_e;

  always_comb begin
    e_d = '0;
    if (!flush_e) begin
      e_d.ctrl = ctrl_d;
      e_d.rs1  = rs1_d;
      e_d.rs2  = rs2_d;
      e_d.rd   = rd_d;
    end
  end

  always_comb begin
    m_d            = '0;
    m_d.reg_write  = e_q.ctrl.reg_write;
    m_d.result_src = e_q.ctrl.result_src;
    m_d.mem_write  = e_q.ctrl.mem_write;
    m_d.rd         = e_q.rd;
  end

  always_comb begin
    w_d            = '0;
    w_d.reg_write  = m_q.reg_write;
    w_d.result_src = m_q.result_src;
    w_d.rd         = m_q.rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign hit_m_a = m_q.reg_write && (e_q.rs1 != '0)
                && (e_q.rs1 == m_q.rd);
  assign hit_w_a = w_q.reg_write && (e_q.rs1 != '0)
                && (e_q.rs1 == w_q.rd);
  assign hit_m_b = m_q.reg_write && (e_q.rs2 != '0)
                && (e_q.rs2 == m_q.rd);
  assign hit_w_b = w_q.reg_write && (e_q.rs2 != '0)
                && (e_q.rs2 == w_q.rd);

  // The younger producer in M shadows an older one in W.
  always_comb begin
    forward_a_e = FWD_RF;
    priority case (1'b1)
      hit_m_a: forward_a_e = FWD_MEM;
      hit_w_a: forward_a_e = FWD_WB;
      default: forward_a_e = FWD_RF;
    endcase
  end

  always_comb begin
    forward_b_e = FWD_RF;
    priority case (1'b1)
      hit_m_b: forward_b_e = FWD_MEM;
      hit_w_b: forward_b_e = FWD_WB;
      default: forward_b_e = FWD_RF;
    endcase
  end

  assign alu_control_e = e_q.ctrl.alu_control;
  assign alu_src_e     = e_q.ctrl.alu_src;
  assign mem_write_m   = m_q.mem_write;
  assign result_src_w  = w_q.result_src;
  assign reg_write_w   = w_q.reg_write;
  assign rd_w          = w_q.rd;

`ifdef CTRL_PIPE_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lw_stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
    end
    if (pc_src_e && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + PERF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: directed instruction stream,
// expectations queued by cycle and checked by an independent monitor.
module tb_ctrl_pipe_hazard;

`ifdef CTRL_PIPE_PERF_EN
  localparam int CW   = 2;
  localparam int PERF = 1;
`else
  localparam int CW   = 32;
  localparam int PERF = 0;
`endif

  localparam logic [9:0] ADD  = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
  localparam logic [9:0] SUB  = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0};
  localparam logic [9:0] AND2 = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
  localparam logic [9:0] LW   = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
  localparam logic [9:0] SW   = {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1};
  localparam logic [9:0] BR   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0};
  localparam logic [9:0] JAL  = {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
  localparam logic [9:0] LWJ  = {1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1};
  localparam logic [9:0] NOP  = 10'h000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    ctrl_d;
  logic [4:0]    rs1_d, rs2_d, rd_d;
  logic          zero_e;
  logic [2:0]    alu_control_e;
  logic          alu_src_e, mem_write_m, reg_write_w;
  logic [1:0]    result_src_w, forward_a_e, forward_b_e;
  logic [4:0]    rd_w;
  logic          pc_src_e, stall_f, stall_d, flush_d;
  logic [CW-1:0] stall_cnt, flush_cnt;

  ctrl_pipe_hazard #(.REG_AW(5), .PERF_CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctrl_d        (ctrl_d),
    .rs1_d         (rs1_d),
    .rs2_d         (rs2_d),
    .rd_d          (rd_d),
    .zero_e        (zero_e),
    .alu_control_e (alu_control_e),
    .alu_src_e     (alu_src_e),
    .mem_write_m   (mem_write_m),
    .result_src_w  (result_src_w),
    .reg_write_w   (reg_write_w),
    .rd_w          (rd_w),
    .forward_a_e   (forward_a_e),
    .forward_b_e   (forward_b_e),
    .pc_src_e      (pc_src_e),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {
    S_ALU, S_ASRC, S_MW, S_RSW, S_RWW, S_RDW, S_FA,
    S_FB, S_PC, S_SF, S_SD, S_FD, S_SC, S_FC
  } sig_e;

  typedef struct {
    int    cyc;
    sig_e  sel;
    int    val;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  function automatic int act(sig_e s);
    case (s)
      S_ALU:   return int'(alu_control_e);
      S_ASRC:  return int'(alu_src_e);
      S_MW:    return int'(mem_write_m);
      S_RSW:   return int'(result_src_w);
      S_RWW:   return int'(reg_write_w);
      S_RDW:   return int'(rd_w);
      S_FA:    return int'(forward_a_e);
      S_FB:    return int'(forward_b_e);
      S_PC:    return int'(pc_src_e);
      S_SF:    return int'(stall_f);
      S_SD:    return int'(stall_d);
      S_FD:    return int'(flush_d);
      S_SC:    return int'(stall_cnt);
      S_FC:    return int'(flush_cnt);
      default: return -1;
    endcase
  endfunction

  function automatic void expect_at(int d, sig_e s, int v, string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.sel  = s;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endfunction

  function automatic void expect_idle(string nm);
    for (int s = 0; s <= int'(S_FC); s++) begin
      expect_at(0, sig_e'(s), 0, nm);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        n_chk++;
        if (sbq[i].cyc == cyc && act(sbq[i].sel) == sbq[i].val) begin
          n_pass++;
        end else begin
          $display("FAIL %s (sig %0d) cyc %0d: got %0d, expected %0d at cyc %0d",
                   sbq[i].name, int'(sbq[i].sel), cyc,
                   act(sbq[i].sel), sbq[i].val, sbq[i].cyc);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic drive(logic [9:0] c, logic [4:0] a, logic [4:0] b,
                       logic [4:0] d, logic z);
    @(posedge clk);
    #1;
    ctrl_d = c;
    rs1_d  = a;
    rs2_d  = b;
    rd_d   = d;
    zero_e = z;
  endtask

  initial begin
    rst_n  = 1'b0;
    ctrl_d = 10'h3FF;
    rs1_d  = 5'd31;
    rs2_d  = 5'd31;
    rd_d   = 5'd31;
    zero_e = 1'b1;

    // power-on reset with an all-ones control word on the inputs
    repeat (2) begin
      drive(10'h3FF, 5'd31, 5'd31, 5'd31, 1'b1);
      expect_idle("por_idle");
    end
    #1;
    n_chk++;
    if (reg_write_w === 1'b0 && rd_w === 5'd0 && pc_src_e === 1'b0) begin
      n_pass++;
    end else begin
      $display("FAIL por_direct: rw=%0b rd=%0d pc=%0b",
               reg_write_w, rd_w, pc_src_e);
    end

    // latency from release
    drive(AND2, 5'd1, 5'd2, 5'd5, 1'b0);
    rst_n = 1'b1;
    expect_at(1, S_ALU, 2, "lat_alu_e");
    expect_at(1, S_ASRC, 0, "lat_alusrc_e");
    expect_at(2, S_RWW, 0, "lat_rw_early");
    expect_at(3, S_RWW, 1, "lat_rw_w");
    expect_at(3, S_RDW, 5, "lat_rd_w");
    expect_at(3, S_RSW, 0, "lat_rs_w");

    // forward from M (priority over W)
    drive(ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    drive(SUB, 5'd1, 5'd2, 5'd3, 1'b0);
    drive(ADD, 5'd3, 5'd3, 5'd4, 1'b0);
    expect_at(1, S_FA, 2, "fwd_m_a");
    expect_at(1, S_FB, 2, "fwd_m_b");

    // forward from W
    drive(ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    drive(ADD, 5'd1, 5'd2, 5'd8, 1'b0);
    drive(ADD, 5'd3, 5'd3, 5'd4, 1'b0);
    expect_at(1, S_FA, 1, "fwd_w_a");
    expect_at(1, S_FB, 1, "fwd_w_b");

    // mixed sources
    drive(ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    drive(ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    drive(ADD, 5'd9, 5'd3, 5'd4, 1'b0);
    expect_at(1, S_FA, 2, "fwd_mix_a");
    expect_at(1, S_FB, 1, "fwd_mix_b");

    // x0 never forwards
    drive(ADD, 5'd1, 5'd2, 5'd0, 1'b0);
    drive(ADD, 5'd0, 5'd0, 5'd4, 1'b0);
    expect_at(1, S_FA, 0, "fwd_x0_a");
    expect_at(1, S_FB, 0, "fwd_x0_b");

    // load-use on rs1
    drive(LW, 5'd1, 5'd0, 5'd6, 1'b0);
    drive(AND2, 5'd6, 5'd2, 5'd7, 1'b0);
    expect_at(0, S_SF, 1, "lu_stall_f");
    expect_at(0, S_SD, 1, "lu_stall_d");
    expect_at(0, S_FD, 0, "lu_no_flush");
    #1;
    n_chk++;
    if (stall_f === 1'b1 && stall_d === stall_f) begin
      n_pass++;
    end else begin
      $display("FAIL lu_direct: sf=%0b sd=%0b", stall_f, stall_d);
    end
    drive(AND2, 5'd6, 5'd2, 5'd7, 1'b0);
    expect_at(0, S_SF, 0, "lu_one_cycle");
    expect_at(0, S_ALU, 0, "lu_bubble_alu");
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_at(0, S_ALU, 2, "lu_resume_alu");
    expect_at(0, S_FA, 1, "lu_fwd_w_a");
    expect_at(0, S_FB, 0, "lu_fwd_none_b");
    expect_at(0, S_RSW, 1, "lu_rs_w");
    expect_at(0, S_RDW, 6, "lu_rd_w");

    // load-use on rs2
    drive(LW, 5'd1, 5'd0, 5'd6, 1'b0);
    drive(AND2, 5'd2, 5'd6, 5'd7, 1'b0);
    expect_at(0, S_SF, 1, "lu_rs2_stall");
    drive(AND2, 5'd2, 5'd6, 5'd7, 1'b0);
    expect_at(0, S_SD, 0, "lu_rs2_release");

    // load to x0 never stalls
    drive(LW, 5'd1, 5'd0, 5'd0, 1'b0);
    drive(AND2, 5'd0, 5'd0, 5'd7, 1'b0);
    expect_at(0, S_SF, 0, "lu_x0_nostall");

    // taken branch
    drive(BR, 5'd1, 5'd2, 5'd0, 1'b0);
    drive(AND2, 5'd1, 5'd2, 5'd10, 1'b1);
    expect_at(0, S_PC, 1, "br_pc_src");
    expect_at(0, S_FD, 1, "br_flush_d");
    expect_at(0, S_SF, 0, "br_no_stall");
    #1;
    n_chk++;
    if (pc_src_e === 1'b1 && flush_d === pc_src_e) begin
      n_pass++;
    end else begin
      $display("FAIL br_direct: pc=%0b fd=%0b", pc_src_e, flush_d);
    end
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_at(0, S_ALU, 0, "br_bubble_alu");
    expect_at(0, S_PC, 0, "br_bubble_pc");

    // not-taken branch
    drive(BR, 5'd1, 5'd2, 5'd0, 1'b0);
    drive(AND2, 5'd1, 5'd2, 5'd10, 1'b0);
    expect_at(0, S_PC, 0, "bnt_pc_src");
    expect_at(0, S_FD, 0, "bnt_flush_d");
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_at(0, S_ALU, 2, "bnt_kept_alu");

    // jump redirects with zero_e low
    drive(JAL, 5'd0, 5'd0, 5'd1, 1'b0);
    expect_at(3, S_RSW, 2, "jal_rs_w");
    expect_at(3, S_RDW, 1, "jal_rd_w");
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_at(0, S_PC, 1, "jal_pc_src");
    expect_at(0, S_FD, 1, "jal_flush_d");

    // store reaches M; then stall and redirect together
    drive(SW, 5'd1, 5'd2, 5'd0, 1'b0);
    expect_at(0, S_PC, 0, "jal_bubble_pc");
    expect_at(2, S_MW, 1, "sw_mem_write");
    drive(LWJ, 5'd1, 5'd0, 5'd5, 1'b0);
    drive(AND2, 5'd5, 5'd2, 5'd7, 1'b0);
    expect_at(0, S_SF, 1, "both_stall_f");
    expect_at(0, S_SD, 1, "both_stall_d");
    expect_at(0, S_FD, 1, "both_flush_d");
    drive(AND2, 5'd5, 5'd2, 5'd7, 1'b0);
    expect_at(0, S_ALU, 0, "both_bubble_alu");
    expect_at(0, S_SF, 0, "both_release");

    // mid-stream reset
    drive(10'h3FF, 5'd31, 5'd31, 5'd31, 1'b1);
    rst_n = 1'b0;
    expect_idle("mid_rst_idle");
    drive(10'h3FF, 5'd31, 5'd31, 5'd31, 1'b1);
    expect_idle("mid_rst_hold");
    drive(AND2, 5'd1, 5'd2, 5'd11, 1'b0);
    rst_n = 1'b1;
    expect_at(2, S_RWW, 0, "rel_rw_early");
    expect_at(3, S_RWW, 1, "rel_rw_w");
    expect_at(3, S_RDW, 11, "rel_rd_w");

    // three load-use stalls
    for (int k = 0; k < 3; k++) begin
      drive(LW, 5'd1, 5'd0, 5'd6, 1'b0);
      drive(AND2, (k == 1) ? 5'd2 : 5'd6, (k == 1) ? 5'd6 : 5'd2,
            5'd7, 1'b0);
      expect_at(0, S_SF, 1, "perf_stall");
      drive(AND2, 5'd6, 5'd2, 5'd7, 1'b0);
    end
    expect_at(0, S_SC, PERF ? 3 : 0, "cnt_stall_3");

    // two taken branches
    for (int k = 0; k < 2; k++) begin
      drive(BR, 5'd1, 5'd2, 5'd0, 1'b0);
      drive(NOP, 5'd0, 5'd0, 5'd0, 1'b1);
      expect_at(0, S_PC, 1, "perf_taken");
    end
    drive(JAL, 5'd0, 5'd0, 5'd1, 1'b0);
    expect_at(0, S_FC, PERF ? 2 : 0, "cnt_flush_2");
    expect_at(0, S_SC, PERF ? 3 : 0, "cnt_stall_keep");

    // push the flush counter from max-1 through max and past it
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_at(0, S_PC, 1, "perf_jump1");
    drive(JAL, 5'd0, 5'd0, 5'd1, 1'b0);
    expect_at(0, S_FC, PERF ? 3 : 0, "cnt_flush_max");
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_at(0, S_PC, 1, "perf_jump2");
    drive(LW, 5'd1, 5'd0, 5'd6, 1'b0);
    expect_at(0, S_FC, PERF ? 3 : 0, "cnt_flush_sat");
    drive(AND2, 5'd6, 5'd2, 5'd7, 1'b0);
    expect_at(0, S_SF, 1, "perf_stall4");
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_at(0, S_SC, PERF ? 3 : 0, "cnt_stall_sat");

    repeat (5) @(posedge clk);
    #1;
    foreach (sbq[i]) begin
      n_chk++;
      $display("FAIL %s never checked: got none, expected %0d at cyc %0d",
               sbq[i].name, sbq[i].val, sbq[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    if (n_pass == n_chk && n_chk > 0) begin
      $display("PASS");
    end else begin
      $display("FAIL");
    end
    $finish;
  end

endmodule
